// File: rtl/bh1750_lux_proc_if.sv
// ============================================================================
// Module : bh1750_lux_proc_if
// Brief  : Reader-to-processor bundle: raw sample + busy in, lux/BCD results out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bh1750_lux_proc_if;
    logic [15:0] data;
    logic        busy;
    logic [15:0] lux_inst;
    logic [15:0] lux_avg;
    logic [19:0] bcd;
    logic        valid;
    logic        overrun;

    modport master (
        output data, busy,
        input  lux_inst, lux_avg, bcd, valid, overrun
    );

    modport slave (
        input  data, busy,
        output lux_inst, lux_avg, bcd, valid, overrun
    );
endinterface

`default_nettype wire

// File: rtl/bh1750_lux_proc.sv
// ============================================================================
// Module : bh1750_lux_proc
// Brief  : BH1750 raw count -> lux (raw*5/6), 2^N moving average, packed BCD.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bh1750_lux_proc #(
    parameter int AVG_LOG2 = 2
) (
    input  wire logic         sys_clk,
    input  wire logic         _rst,
    bh1750_lux_proc_if.slave  bus
);

    localparam int c_DEPTH = 1 << AVG_LOG2;
    localparam int c_PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_SW    = 16 + AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIV  = 3'd1,
        S_AVG  = 3'd2,
        S_BCD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_busy_d;
    logic               w_event;
    logic [4:0]         r_cnt;

    logic [18:0]        r_dvd;
    logic [2:0]         r_rem;
    logic [15:0]        r_quot;
    logic [3:0]         w_trial;
    logic               w_ge6;

    logic [15:0]        r_buf [c_DEPTH];
    logic [c_PW-1:0]    r_ptr;
    logic [c_SW-1:0]    r_sum;
    logic [c_SW-1:0]    w_sum_new;
    logic [15:0]        w_avg_new;
    logic               r_primed;
    logic [15:0]        r_avg;

    logic [35:0]        r_dd;
    logic [35:0]        w_dd_adj;
    logic [35:0]        w_dd_shf;

    logic [15:0]        r_lux_inst;
    logic [15:0]        r_lux_avg;
    logic [19:0]        r_bcd;
    logic               r_overrun;

    assign w_event = r_busy_d & ~bus.busy;

    // Restoring divide by 6: the partial remainder never exceeds 5, so 3 bits hold it.
    assign w_trial = {r_rem, r_dvd[18]};
    assign w_ge6   = (w_trial >= 4'd6);

    always_comb begin
        w_sum_new = r_sum;
        if (r_primed)
            w_sum_new = r_sum - c_SW'(r_buf[r_ptr]) + c_SW'(r_quot);
        else
            w_sum_new = c_SW'(r_quot) << AVG_LOG2;
        w_avg_new = 16'(w_sum_new >> AVG_LOG2);
    end

    always_comb begin
        w_dd_adj = r_dd;
        for (int d = 0; d < 5; d++) begin
            if (r_dd[16+4*d +: 4] >= 4'd5)
                w_dd_adj[16+4*d +: 4] = r_dd[16+4*d +: 4] + 4'd3;
        end
        w_dd_shf = {w_dd_adj[34:0], 1'b0};
    end

    always_ff @(posedge sys_clk) begin
        if (_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_event)            w_next = S_DIV;
            S_DIV:  if (r_cnt == 5'd18)     w_next = S_AVG;
            S_AVG:                          w_next = S_BCD;
            S_BCD:  if (r_cnt == 5'd15)     w_next = S_DONE;
            S_DONE:                         w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (_rst) begin
            r_busy_d   <= 1'b0;
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            for (int i = 0; i < c_DEPTH; i++)
                r_buf[i] <= '0;
            r_ptr      <= '0;
            r_sum      <= '0;
            r_primed   <= 1'b0;
            r_avg      <= '0;
            r_dd       <= '0;
            r_lux_inst <= '0;
            r_lux_avg  <= '0;
            r_bcd      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_busy_d <= bus.busy;
            if (w_event && r_state != S_IDLE)
                r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        r_dvd  <= {3'b000, bus.data} * 19'd5;
                        r_rem  <= '0;
                        r_quot <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_DIV: begin
                    r_dvd  <= {r_dvd[17:0], 1'b0};
                    r_rem  <= w_ge6 ? 3'(w_trial - 4'd6) : w_trial[2:0];
                    r_quot <= {r_quot[14:0], w_ge6};
                    r_cnt  <= (r_cnt == 5'd18) ? 5'd0 : r_cnt + 5'd1;
                end
                S_AVG: begin
                    if (r_primed) begin
                        r_buf[r_ptr] <= r_quot;
                        r_ptr        <= (r_ptr == c_PW'(c_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
                    end else begin
                        for (int i = 0; i < c_DEPTH; i++)
                            r_buf[i] <= r_quot;
                        r_primed <= 1'b1;
                    end
                    r_sum <= w_sum_new;
                    r_avg <= w_avg_new;
                    r_dd  <= {20'd0, w_avg_new};
                    r_cnt <= '0;
                end
                S_BCD: begin
                    r_dd  <= w_dd_shf;
                    r_cnt <= r_cnt + 5'd1;
                    // Results land on the edge into DONE so they coincide with valid.
                    if (r_cnt == 5'd15) begin
                        r_lux_inst <= r_quot;
                        r_lux_avg  <= r_avg;
                        r_bcd      <= w_dd_shf[35:16];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.lux_inst = r_lux_inst;
    assign bus.lux_avg  = r_lux_avg;
    assign bus.bcd      = r_bcd;
    assign bus.valid    = (r_state == S_DONE);
    assign bus.overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_bh1750_lux_proc.sv
// ============================================================================
// Module : tb_bh1750_lux_proc
// Brief  : Scoreboard bench for bh1750_lux_proc with hand-computed vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bh1750_lux_proc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bh1750_lux_proc_if u_if ();

    bh1750_lux_proc #(.AVG_LOG2(2)) u_dut (
        .sys_clk (clk),
        ._rst    (rst),
        .bus     (u_if.slave)
    );

    typedef struct {
        logic [15:0] inst;
        logic [15:0] avg;
        logic [19:0] bcd;
        logic        ovr;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_valid = 0;
    int   cyc     = 0;
    int   ev_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per valid pulse
    always @(negedge clk) begin
        if (u_if.valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lux_inst", 32'(u_if.lux_inst), 32'(e.inst));
                chk("lux_avg",  32'(u_if.lux_avg),  32'(e.avg));
                chk("bcd",      32'(u_if.bcd),      32'(e.bcd));
                chk("overrun",  32'(u_if.overrun),  32'(e.ovr));
                chk("latency",  32'(cyc),           32'(e.due));
            end
        end
    end

    task automatic fall(input logic [15:0] raw);
        @(negedge clk);
        u_if.busy = 1'b1;
        @(negedge clk);
        u_if.data = raw;
        u_if.busy = 1'b0;
        ev_cyc    = cyc;
    endtask

    task automatic expect_s(input logic [15:0] inst, input logic [15:0] avg,
                            input logic [19:0] bcd, input logic ovr);
        exp_t e;
        e.inst = inst; e.avg = avg; e.bcd = bcd; e.ovr = ovr; e.due = ev_cyc + 37;
        sb.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 120) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int k;
    int nv;
    logic [15:0] raws  [5] = '{16'd120, 16'd240, 16'd360, 16'd480, 16'd600};
    logic [15:0] insts [5] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
    logic [15:0] avgs  [5] = '{16'd100, 16'd125, 16'd175, 16'd250, 16'd350};
    logic [19:0] bcds  [5] = '{20'h00100, 20'h00125, 20'h00175, 20'h00250, 20'h00350};

    initial begin
        rst       = 1'b1;
        u_if.busy = 1'b0;
        u_if.data = '0;
        repeat (3) @(negedge clk);
        chk("rst_lux_inst", 32'(u_if.lux_inst), 32'd0);
        chk("rst_lux_avg",  32'(u_if.lux_avg),  32'd0);
        chk("rst_bcd",      32'(u_if.bcd),      32'd0);
        chk("rst_valid",    32'(u_if.valid),    32'd0);
        chk("rst_overrun",  32'(u_if.overrun),  32'd0);
        rst = 1'b0;

        // Basic conversion, then averaged follow-ups on a primed buffer
        fall(16'd120);    expect_s(16'd100,   16'd100,   20'h00100, 1'b0); drain();
        fall(16'hFFFF);   expect_s(16'd54612, 16'd13728, 20'h13728, 1'b0); drain();
        fall(16'd7);      expect_s(16'd5,     16'd13704, 20'h13704, 1'b0); drain();
        fall(16'd0);      expect_s(16'd0,     16'd13679, 20'h13679, 1'b0); drain();

        // Boundaries on a freshly primed buffer
        do_reset();
        fall(16'hFFFF);   expect_s(16'd54612, 16'd54612, 20'h54612, 1'b0); drain();
        do_reset();
        fall(16'd0);      expect_s(16'd0,     16'd0,     20'h00000, 1'b0); drain();

        // Moving average ramp
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fall(raws[i]);
            expect_s(insts[i], avgs[i], bcds[i], 1'b0);
            drain();
        end

        // Overrun: second edge 10 cycles into the first computation is dropped
        fall(16'd720);    expect_s(16'd600, 16'd450, 20'h00450, 1'b1);
        repeat (8) @(negedge clk);
        fall(16'd12);
        drain();
        chk("overrun_set", 32'(u_if.overrun), 32'd1);
        fall(16'd12);     expect_s(16'd10, 16'd377, 20'h00377, 1'b1); drain();
        chk("overrun_sticky", 32'(u_if.overrun), 32'd1);

        // Reset during BCD discards the result
        fall(16'd240);
        k = ev_cyc;
        while (cyc < k + 25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_lux_inst", 32'(u_if.lux_inst), 32'd0);
        chk("midrst_lux_avg",  32'(u_if.lux_avg),  32'd0);
        chk("midrst_bcd",      32'(u_if.bcd),      32'd0);
        chk("midrst_overrun",  32'(u_if.overrun),  32'd0);
        repeat (45) @(negedge clk);
        fall(16'd240);    expect_s(16'd200, 16'd200, 20'h00200, 1'b0); drain();

        // Edge landing in the DONE cycle is dropped
        fall(16'd360);    expect_s(16'd300, 16'd225, 20'h00225, 1'b0);
        k = ev_cyc;
        @(negedge clk);
        u_if.busy = 1'b1;
        while (cyc < k + 37) @(negedge clk);
        u_if.data = 16'd0;
        u_if.busy = 1'b0;
        drain();
        chk("overrun_done_drop", 32'(u_if.overrun), 32'd1);

        // Edge in the cycle after DONE is accepted
        do_reset();
        fall(16'd120);    expect_s(16'd100, 16'd100, 20'h00100, 1'b0);
        k = ev_cyc;
        @(negedge clk);
        u_if.busy = 1'b1;
        while (cyc < k + 38) @(negedge clk);
        u_if.data = 16'd240;
        u_if.busy = 1'b0;
        ev_cyc    = cyc;
        expect_s(16'd200, 16'd125, 20'h00125, 1'b0);
        drain();
        chk("overrun_after_done", 32'(u_if.overrun), 32'd0);

        // No transitions -> no valid (busy falls exactly as reset releases)
        @(negedge clk);
        u_if.busy = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        u_if.busy = 1'b0;
        nv = n_valid;
        repeat (60) @(negedge clk);
        chk("no_valid_busy_low", 32'(n_valid), 32'(nv));
        u_if.busy = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_valid_busy_high", 32'(n_valid), 32'(nv));
        chk("idle_lux_inst", 32'(u_if.lux_inst), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
